alu_pipe: RTL
=============

// Module: alu_pipe
// PURPOSE
//  Pipelined, parametrised successor of the CPU's combinational ALU.
//  - Two register stages, with a valid/ready handshake on both sides.
//  - Adds status flags (Z/C/N/V) and an illegal-op error bit.
//  - Sits between decode/operand-fetch and writeback.
//  - Sustains one operation per cycle when the consumer is ready; stalls losslessly under backpressure.
// PARAMETERS
//  WIDTH     7   operand width in bits; the result is WIDTH+1 bits (MSB = carry/borrow)
//  OP_WIDTH  3   opcode width in bits
// PORTS
//  clk        in   1            system clock, rising edge
//  rst_n      in   1            asynchronous, active-low reset
//  in_valid   in   1            operand/opcode bundle valid
//  in_ready   out  1            stage 1 can accept the bundle this cycle
//  alu_op     in   OP_WIDTH     opcode
//  op1        in   WIDTH        first operand
//  op2        in   WIDTH        second operand
//  out_valid  out  1            result valid
//  out_ready  in   1            consumer accepts the result this cycle
//  out        out  WIDTH+1      result
//  flags      out  4            {V,N,C,Z}
//  err        out  1            the issued opcode was illegal
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - both stage valids = 0; out, flags and err = 0.
//   - out_valid = 0; in_ready = 1 on the first cycle after release.
//  Transfers:
//   - Input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
//  Pipeline:
//   - S1 registers {alu_op, op1, op2}.
//   - S2 registers {out, flags, err}, computed combinationally from S1.
//   - s2_adv = !s2_valid | out_ready;  s1_adv = !s1_valid | s2_adv;  in_ready = s1_adv.
//   - in_ready is combinational from out_ready; there is no skid buffer.
//  Latency and throughput:
//   - An accepted input appears at out_valid 2 cycles later if no stall occurs.
//   - Throughput is 1/cycle with out_ready held high.
//  Stalls:
//   - While out_valid & !out_ready, out/flags/err hold stable.
//   - S1 holds its contents if S2 is also full.
//   - No bundle is dropped or duplicated.
//  Simultaneous events: accept and retire in the same cycle are legal at both stages.
//  Reset mid-operation: in-flight bundles are discarded; nothing is emitted afterwards.
//  Opcodes (arithmetic is modulo 2^(WIDTH+1)):
//   001 ADD  out = op1 + op2; C = out[WIDTH]
//   010 SUB  out = op1 - op2; C = out[WIDTH] = borrow
//   011 AND  out = {1'b0, op1 & op2}
//   100 OR   out = {1'b0, op1 | op2}
//   101 XOR  out = {1'b0, op1 ^ op2}
//   000, and any other code not enabled: out = 0, flags = 0, err = 1
//  Flags:
//   - Z = (out[WIDTH-1:0] == 0); N = out[WIDTH-1].
//   - V = signed overflow of the WIDTH-bit result, ADD/SUB only; 0 for other ops.
//   - C = 0 for logic ops.
// CONFIGURATION
//  `ALU_PIPE_SHIFT_EN defined:
//   - Shift amount = op2[$clog2(WIDTH)-1:0].
//   - 110 SHL  out = {op1, 1'b0}-style left shift, truncated to WIDTH+1 bits; C = out[WIDTH].
//   - 111 SHR  out = {1'b0, op1 >> amount}, logical; C = 0.
//   - V = 0 for both shifts.
//  `ALU_PIPE_SHIFT_EN undefined: 110/111 are illegal (out = 0, err = 1).
// STRUCTURE
//  alu_pkg:
//   - opcode localparams OP_ADD..OP_SHR.
//   - flag bit indices FLG_Z=0, FLG_C=1, FLG_N=2, FLG_V=3.
//  Sub-module alu_pipe_core:
//   - combinational {out, flags, err} = f(alu_op, op1, op2), parametrised identically.
//   - alu_pipe instantiates it between S1 and S2.
//   - alu_pipe_core alone holds the opcode decode.
// TESTING (WIDTH=7)
//  1. ADD 60+10, out_ready=1 -> 2 cycles later out=8'h46, flags V=1 N=1 C=0 Z=0, err=0.
//  2. SUB 5-7 -> out=8'hFE, C=1 N=1 V=0 Z=0; SUB 9-9 -> out=0, Z=1, C=0.
//  3. AND 7'h55&7'h0F -> out=8'h05; op 000 -> out=0, err=1.
//  4. Stream 8 back-to-back ADDs, out_ready low cycles 3-5 -> 8 results in order,
//     none lost or repeated, outputs stable while stalled, in_ready=0 once both stages full.
//  5. Assert rst_n=0 with both stages full -> out_valid=0, in_ready=1 after release, no stale result.
//  6. SHL 7'h41 by 1 -> SHIFT_EN: out=8'h82, C=1; without: out=0, err=1.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and flag bit positions shared by alu_pipe and alu_pipe_core.
// The shift opcodes only decode as legal when ALU_PIPE_SHIFT_EN is defined.
package alu_pkg;

  localparam logic [2:0] OP_ILL = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  localparam int FLG_Z = 0;
  localparam int FLG_C = 1;
  localparam int FLG_N = 2;
  localparam int FLG_V = 3;

endpackage

// File: rtl/alu_pipe_core.sv
// alu_pipe_core: purely combinational ALU function {out, flags, err} = f(alu_op, op1, op2).
// Holds the only opcode decode in the design.
// Optional feature: ALU_PIPE_SHIFT_EN enables SHL (110) and SHR (111); otherwise they are illegal.
module alu_pipe_core
  import alu_pkg::*;
#(
  parameter int WIDTH    = 7,
  parameter int OP_WIDTH = 3
) (
  input  logic [OP_WIDTH-1:0] alu_op,
  input  logic [WIDTH-1:0]    op1,
  input  logic [WIDTH-1:0]    op2,
  output logic [WIDTH:0]      res,
  output logic [3:0]          flags,
  output logic                err
);

  localparam logic [OP_WIDTH-1:0] C_ADD = OP_WIDTH'(OP_ADD);
  localparam logic [OP_WIDTH-1:0] C_SUB = OP_WIDTH'(OP_SUB);
  localparam logic [OP_WIDTH-1:0] C_AND = OP_WIDTH'(OP_AND);
  localparam logic [OP_WIDTH-1:0] C_OR  = OP_WIDTH'(OP_OR);
  localparam logic [OP_WIDTH-1:0] C_XOR = OP_WIDTH'(OP_XOR);
`ifdef ALU_PIPE_SHIFT_EN
  localparam logic [OP_WIDTH-1:0] C_SHL = OP_WIDTH'(OP_SHL);
  localparam logic [OP_WIDTH-1:0] C_SHR = OP_WIDTH'(OP_SHR);
  localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  logic [SHW-1:0] amt;
  assign amt = op2[SHW-1:0];
`endif

  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] b_ext;
  logic           carry;
  logic           ovf;

  assign a_ext = {1'b0, op1};
  assign b_ext = {1'b0, op2};

  // Opcode decode, result/carry/overflow generation and flag packing.
  always_comb begin
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    err   = 1'b0;
    flags = '0;
    case (alu_op)
      C_ADD: begin
        res   = a_ext + b_ext;
        carry = res[WIDTH];
        // Same-sign operands producing a different-sign result overflow.
        ovf   = (op1[WIDTH-1] == op2[WIDTH-1]) && (res[WIDTH-1] != op1[WIDTH-1]);
      end
      C_SUB: begin
        res   = a_ext - b_ext;
        carry = res[WIDTH];
        // Opposite-sign operands where the result sign differs from op1 overflow.
        ovf   = (op1[WIDTH-1] != op2[WIDTH-1]) && (res[WIDTH-1] != op1[WIDTH-1]);
      end
      C_AND: res = {1'b0, op1 & op2};
      C_OR:  res = {1'b0, op1 | op2};
      C_XOR: res = {1'b0, op1 ^ op2};
`ifdef ALU_PIPE_SHIFT_EN
      C_SHL: begin
        res   = a_ext << amt;
        carry = res[WIDTH];
      end
      C_SHR: res = {1'b0, op1 >> amt};
`endif
      default: err = 1'b1;
    endcase
    // Illegal opcodes report no flags at all, not even Z on the zero result.
    if (!err) begin
      flags[FLG_Z] = (res[WIDTH-1:0] == '0);
      flags[FLG_C] = carry;
      flags[FLG_N] = res[WIDTH-1];
      flags[FLG_V] = ovf;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready on both sides.
// S1 holds {alu_op, op1, op2}; S2 holds {out, flags, err} computed by alu_pipe_core.
// Ready propagates combinationally backwards (no skid buffer).
// Optional feature: ALU_PIPE_SHIFT_EN (passed through to alu_pipe_core).
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH    = 7,
  parameter int OP_WIDTH = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OP_WIDTH-1:0] alu_op,
  input  logic [WIDTH-1:0]    op1,
  input  logic [WIDTH-1:0]    op2,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH:0]      out,
  output logic [3:0]          flags,
  output logic                err
);

  logic                s1_valid_q, s1_valid_d;
  logic [OP_WIDTH-1:0] s1_op_q, s1_op_d;
  logic [WIDTH-1:0]    s1_a_q, s1_a_d;
  logic [WIDTH-1:0]    s1_b_q, s1_b_d;

  logic                s2_valid_q, s2_valid_d;
  logic [WIDTH:0]      out_q, out_d;
  logic [3:0]          flags_q, flags_d;
  logic                err_q, err_d;

  logic                s1_adv;
  logic                s2_adv;
  logic [WIDTH:0]      core_res;
  logic [3:0]          core_flags;
  logic                core_err;

  alu_pipe_core #(
    .WIDTH    (WIDTH),
    .OP_WIDTH (OP_WIDTH)
  ) u_core (
    .alu_op (s1_op_q),
    .op1    (s1_a_q),
    .op2    (s1_b_q),
    .res    (core_res),
    .flags  (core_flags),
    .err    (core_err)
  );

  // A stage may advance when it is empty or its downstream stage advances.
  always_comb begin
    s2_adv = !s2_valid_q || out_ready;
    s1_adv = !s1_valid_q || s2_adv;
  end

  // Next-state for both stages; data registers only load on an actual transfer.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s2_valid_d = s2_valid_q;
    out_d      = out_q;
    flags_d    = flags_q;
    err_d      = err_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_op_d = alu_op;
        s1_a_d  = op1;
        s1_b_d  = op2;
      end
    end
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_d   = core_res;
        flags_d = core_flags;
        err_d   = core_err;
      end
    end
  end

  // Pipeline registers; reset discards any in-flight bundles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      out_q      <= '0;
      flags_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_valid_q <= s2_valid_d;
      out_q      <= out_d;
      flags_q    <= flags_d;
      err_q      <= err_d;
    end
  end

  assign in_ready  = s1_adv;
  assign out_valid = s2_valid_q;
  assign out       = out_q;
  assign flags     = flags_q;
  assign err       = err_q;

endmodule
